// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - single-op issue/retire controller upstream of the ALU (optional stats: ALU_ISSUE_STATS_EN)
module alu_issue_ctrl #(
  parameter int DATA_W  = 32,
  parameter int OPC_W   = 3,
  parameter int DEST_W  = 5,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_operand1,
  input  logic [DATA_W-1:0] in_operand2,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic [DEST_W-1:0] in_dest,
  output logic [DATA_W-1:0] alu_operand1,
  output logic [DATA_W-1:0] alu_operand2,
  output logic [OPC_W-1:0]  alu_opcode,
  output logic              alu_en,
  input  logic [DATA_W:0]   alu_result,
  input  logic              alu_overflow,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W:0]   out_result,
  output logic              out_overflow,
  output logic [DEST_W-1:0] out_dest,
  output logic              busy
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]       op_count,
  output logic [15:0]       ovf_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // WAIT lasts ALU_LAT cycles: counter loaded with ALU_LAT-1, result taken when it hits 0
  localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   op1_q, op1_d;
  logic [DATA_W-1:0]   op2_q, op2_d;
  logic [OPC_W-1:0]    opc_q, opc_d;
  logic [DEST_W-1:0]   dest_q, dest_d;
  logic [DATA_W:0]     res_q, res_d;
  logic                ovf_q, ovf_d;
  logic                accept;
  logic                out_hs;

  // Next-state, handshakes and op/result capture
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    opc_d     = opc_q;
    dest_d    = dest_q;
    res_d     = res_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    alu_en    = 1'b0;
    accept    = 1'b0;
    out_hs    = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        alu_en  = 1'b1;
        cnt_d   = CNT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          res_d   = alu_result;
          ovf_d   = alu_overflow;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        out_valid = 1'b1;
        // A new op may enter only in the cycle WB takes the current result
        in_ready  = out_ready;
        if (out_ready) begin
          out_hs = 1'b1;
          if (in_valid) begin
            accept  = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      op1_d  = in_operand1;
      op2_d  = in_operand2;
      opc_d  = in_opcode;
      dest_d = in_dest;
    end
  end

  // State and datapath registers; reset drops any in-flight op
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      opc_q   <= '0;
      dest_q  <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      opc_q   <= opc_d;
      dest_q  <= dest_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  assign alu_operand1 = op1_q;
  assign alu_operand2 = op2_q;
  assign alu_opcode   = opc_q;
  assign out_result   = res_q;
  assign out_overflow = ovf_q;
  assign out_dest     = dest_q;
  assign busy         = (state_q != S_IDLE);

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] op_count_q, op_count_d;
  logic [15:0] ovf_count_q, ovf_count_d;

  // Retired-op and overflow counters, both wrap naturally at 16 bits
  always_comb begin
    op_count_d  = op_count_q;
    ovf_count_d = ovf_count_q;
    if (out_hs) begin
      op_count_d = op_count_q + 16'd1;
      if (ovf_q) begin
        ovf_count_d = ovf_count_q + 16'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q  <= '0;
      ovf_count_q <= '0;
    end else begin
      op_count_q  <= op_count_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  assign op_count  = op_count_q;
  assign ovf_count = ovf_count_q;
`endif

endmodule
